// File: rtl/vga_frame_fetch_if.sv
// Memory read port and pixel stream bundle for vga_frame_fetch.
interface vga_frame_fetch_if #(parameter int ADDR_WIDTH = 32);
    logic                  o_Mem_Req;
    logic [ADDR_WIDTH-1:0] o_Mem_Addr;
    logic                  i_Mem_Ack;
    logic [15:0]           i_Mem_Rdata;
    logic                  i_Mem_Rvalid;
    logic [15:0]           m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;

    modport master (
        output o_Mem_Req, o_Mem_Addr,
        input  i_Mem_Ack, i_Mem_Rdata, i_Mem_Rvalid,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport slave (
        input  o_Mem_Req, o_Mem_Addr,
        output i_Mem_Ack, i_Mem_Rdata, i_Mem_Rvalid,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/vga_frame_fetch.sv
// Framebuffer fetch: per frame-sync, reads one frame of 16-bit pixels into a
// credit-limited FIFO and streams it out; page flips land on frame boundaries.
module vga_frame_fetch #(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Frame_Sync,
    input  logic [ADDR_WIDTH-1:0] i_Back_Base,
    input  logic                  i_Flip_Req,
    output logic                  o_Flip_Done,
    output logic [ADDR_WIDTH-1:0] o_Front_Base,
    output logic                  o_Busy,
    output logic                  o_Frame_Error,
    vga_frame_fetch_if.master     bus
);
    localparam int TOTAL = H_PIXELS * V_LINES;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int IW    = $clog2(TOTAL + 1);
    localparam int XW    = $clog2(H_PIXELS + 1);
    localparam int YW    = $clog2(V_LINES + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, FETCH, ABORT} state_t;

    state_t                state_q, state_d;
    logic                  sync_q, sync_d, pend_q, pend_d, done_q, done_d;
    logic                  err_q, err_d, req_q, req_d;
    logic [ADDR_WIDTH-1:0] back_q, back_d, front_q, front_d, addr_q, addr_d;
    logic [IW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         outst_q, outst_d, cnt_q, cnt_d;
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [15:0]           mem_q [FIFO_DEPTH];
    logic                  sync_edge, ack, rsp, push, pop, start, abort, frame_done, tvalid;

    assign tvalid = (cnt_q != '0);

    always_comb begin
        sync_d     = i_Frame_Sync;
        sync_edge  = i_Frame_Sync && !sync_q;
        ack        = req_q && bus.i_Mem_Ack;
        rsp        = bus.i_Mem_Rvalid && (outst_q != '0);
        pop        = tvalid && bus.m_axis_tready;
        frame_done = (issued_q == IW'(TOTAL)) && (outst_q == '0) && (cnt_q == '0);

        // A flip request in the sync-edge cycle wins over an older pending one.
        pend_d  = pend_q;
        back_d  = back_q;
        front_d = front_q;
        done_d  = 1'b0;
        if (sync_edge) begin
            if (i_Flip_Req) begin
                front_d = i_Back_Base & ALIGN;
                done_d  = 1'b1;
                pend_d  = 1'b0;
            end else if (pend_q) begin
                front_d = back_q;
                done_d  = 1'b1;
                pend_d  = 1'b0;
            end
        end else if (i_Flip_Req) begin
            pend_d = 1'b1;
            back_d = i_Back_Base & ALIGN;
        end

        state_d = state_q;
        err_d   = err_q;
        start   = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE:  start = sync_edge;
            FETCH: begin
                if (sync_edge) begin
                    start = frame_done;
                    abort = !frame_done;
                end else if (frame_done) begin
                    state_d = IDLE;
                end
            end
            ABORT:   start = (outst_q == '0) && !req_q;
            default: state_d = IDLE;
        endcase
        if (start) state_d = FETCH;
        if (abort) begin
            state_d = ABORT;
            err_d   = 1'b1;
        end

        outst_d = outst_q + CW'(ack) - CW'(rsp);
        push    = rsp && (state_q == FETCH) && !abort;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        wr_d    = push ? wr_q + PW'(1) : wr_q;
        rd_d    = pop  ? rd_q + PW'(1) : rd_q;
        if (abort) begin
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end

        x_d = x_q;
        y_d = y_q;
        if (pop) begin
            if (x_q == XW'(H_PIXELS - 1)) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        addr_d   = addr_q;
        issued_d = issued_q;
        if (ack) begin
            addr_d   = addr_q + ADDR_WIDTH'(2);
            issued_d = issued_q + IW'(1);
        end
        if (start) begin
            addr_d   = front_d;
            issued_d = '0;
            x_d      = '0;
            y_d      = '0;
        end

        // An un-acked request is held as-is; a new one needs a free FIFO slot
        // after counting everything already stored or in flight.
        req_d = req_q;
        if (!req_q || ack)
            req_d = (state_d == FETCH) && (issued_d != IW'(TOTAL)) &&
                    ((int'(cnt_d) + int'(outst_d)) < FIFO_DEPTH);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            sync_q   <= 1'b1;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            back_q   <= '0;
            front_q  <= '0;
            addr_q   <= '0;
            issued_q <= '0;
            outst_q  <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            err_q    <= err_d;
            req_q    <= req_d;
            back_q   <= back_d;
            front_q  <= front_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_q] <= bus.i_Mem_Rdata;
    end

    assign o_Flip_Done       = done_q;
    assign o_Front_Base      = front_q;
    assign o_Busy            = (state_q != IDLE);
    assign o_Frame_Error     = err_q;
    assign bus.o_Mem_Req     = req_q;
    assign bus.o_Mem_Addr    = addr_q;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = tvalid ? mem_q[rd_q] : '0;
    assign bus.m_axis_tlast  = tvalid && (x_q == XW'(H_PIXELS - 1));
    assign bus.m_axis_tuser  = tvalid && (x_q == '0) && (y_q == '0);
endmodule

// File: tb/tb_vga_frame_fetch.sv
// Randomized bench for vga_frame_fetch: memory/sink model plus frame-order reference.
module tb_vga_frame_fetch;
    localparam int H = 8, V = 4, AW = 32, D = 8, TOT = H * V;

    logic          clk = 1'b0;
    logic          rst, sync, flip, flip_done, busy, ferr;
    logic [AW-1:0] back, front;

    vga_frame_fetch_if #(.ADDR_WIDTH(AW)) bus();

    vga_frame_fetch #(.H_PIXELS(H), .V_LINES(V), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Frame_Sync(sync), .i_Back_Base(back),
        .i_Flip_Req(flip), .o_Flip_Done(flip_done), .o_Front_Base(front),
        .o_Busy(busy), .o_Frame_Error(ferr), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          due;
        int          gen;
    } rsp_t;

    rsp_t          rq[$];
    int            checks = 0, fails = 0, cyc = 0;
    int            lat_min, lat_max, ack_pct, rdy_mode;
    int            exp_idx, beats, acks, flips, disc, gen, max_infl, exp_disc;
    logic [AW-1:0] exp_base, held_addr;
    bit            held_pending;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_addr"}, {bus.o_Mem_Addr, front}, 64'd0);
        chk({tag, "_ctl"}, {bus.o_Mem_Req, flip_done, bus.m_axis_tvalid, bus.m_axis_tdata,
                            bus.m_axis_tlast, bus.m_axis_tuser, busy, ferr}, 64'd0);
    endtask

    // Memory and sink decisions are made on the falling edge and take effect at the next rising edge.
    task automatic tick();
        rsp_t r;
        @(negedge clk);
        cyc++;
        if (flip_done === 1'b1) flips++;
        bus.i_Mem_Rvalid = 1'b0;
        bus.i_Mem_Rdata  = '0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            bus.i_Mem_Rvalid = 1'b1;
            bus.i_Mem_Rdata  = r.data;
            if (r.gen != gen) disc++;
        end
        bus.i_Mem_Ack = 1'b0;
        if (bus.o_Mem_Req === 1'b1 && $urandom_range(99) < ack_pct) begin
            bus.i_Mem_Ack = 1'b1;
            acks++;
            r.data = bus.o_Mem_Addr[15:0];
            r.due  = cyc + $urandom_range(lat_max, lat_min);
            r.gen  = gen;
            if (held_pending) begin
                chk("held_addr", bus.o_Mem_Addr, held_addr);
                r.gen = gen - 1;
                held_pending = 1'b0;
            end
            rq.push_back(r);
        end
        case (rdy_mode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = (cyc % 3 == 0);
            2:       bus.m_axis_tready = 1'b0;
            default: bus.m_axis_tready = 1'($urandom_range(1));
        endcase
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            chk("beat", {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata},
                {exp_idx == 0, (exp_idx % H) == H - 1, 16'(exp_base + 2 * exp_idx)});
            exp_idx++;
            beats++;
        end
        if (acks - beats > max_infl) max_infl = acks - beats;
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input bit with_flip, input logic [AW-1:0] fa);
        exp_base = base; exp_idx = 0; beats = 0; acks = 0; flips = 0; max_infl = 0;
        sync = 1'b1;
        if (with_flip) begin
            flip = 1'b1;
            back = fa;
        end
        tick();
        flip = 1'b0;
        chk("sync_req", bus.o_Mem_Req, 1);
        chk("sync_addr", bus.o_Mem_Addr, base);
        chk("sync_front", front, base);
        repeat (3) tick();
        sync = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int n = 0; n < max && busy; n++) tick();
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_beats(input int n, input int max);
        for (int k = 0; k < max && exp_idx < n; k++) tick();
        chk("beat_timeout", exp_idx >= n, 1);
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; flip = 1'b0; back = '0;
        bus.i_Mem_Ack = 1'b0; bus.i_Mem_Rvalid = 1'b0; bus.i_Mem_Rdata = '0; bus.m_axis_tready = 1'b0;
        lat_min = 0; lat_max = 0; ack_pct = 100; rdy_mode = 0;
        gen = 0; disc = 0; held_pending = 1'b0; exp_base = '0; exp_idx = 0;
        beats = 0; acks = 0; flips = 0; max_infl = 0; held_addr = '0; exp_disc = 0;
        repeat (3) @(negedge clk);
        chk_rst_outs("rst");
        rst = 1'b0;
        tick();
        chk_rst_outs("post_rst");

        // Frame 1: flip queued before sync (bit 0 dropped), zero-latency memory, mid-frame flip.
        back = 32'h1001; flip = 1'b1;
        tick();
        flip = 1'b0;
        chk("flip_pending_front", front, 0);
        start_frame(32'h1000, 1'b0, '0);
        wait_beats(8, 200);
        back = 32'h2000; flip = 1'b1;
        tick();
        flip = 1'b0;
        wait_idle(2000);
        chk("f1_beats", beats, TOT);
        chk("f1_err", ferr, 0);
        chk("f1_flips", flips, 1);
        chk("f1_front", front, 32'h1000);

        // Frame 2: pending flip applies, latency 5, ready 1-of-3, irregular acks.
        lat_min = 5; lat_max = 5; rdy_mode = 1; ack_pct = 70;
        start_frame(32'h2000, 1'b0, '0);
        wait_idle(4000);
        chk("f2_beats", beats, TOT);
        chk("f2_flips", flips, 1);
        chk("f2_credit", max_infl <= D, 1);

        // Frame 3: flip in the sync-edge cycle, random latency and ready.
        lat_min = 0; lat_max = 4; rdy_mode = 3; ack_pct = 80;
        start_frame(32'h3000, 1'b1, 32'h3000);
        wait_idle(4000);
        chk("f3_beats", beats, TOT);
        chk("f3_flips", flips, 1);
        chk("f3_credit", max_infl <= D, 1);
        chk("f3_err", ferr, 0);

        // Abort: sync edge mid-frame with a held request and reads in flight.
        lat_min = 3; lat_max = 3; rdy_mode = 0; ack_pct = 100;
        start_frame(32'h3000, 1'b0, '0);
        wait_beats(10, 200);
        ack_pct = 0; rdy_mode = 2;
        tick();
        held_pending = bus.o_Mem_Req;
        held_addr    = bus.o_Mem_Addr;
        exp_disc     = rq.size() + (bus.o_Mem_Req ? 1 : 0);
        gen++; disc = 0; exp_idx = 0; beats = 0; flips = 0;
        sync = 1'b1; ack_pct = 100; rdy_mode = 0;
        tick();
        chk("abort_tvalid", bus.m_axis_tvalid, 0);
        chk("abort_err", ferr, 1);
        chk("abort_busy", busy, 1);
        repeat (3) tick();
        sync = 1'b0;
        wait_idle(2000);
        chk("abort_disc", disc, exp_disc);
        chk("abort_held_done", held_pending, 0);
        chk("abort_beats", beats, TOT);
        chk("abort_err_sticky", ferr, 1);

        // Reset mid-frame: outputs clear at once, nothing streams until the next sync.
        lat_min = 2; lat_max = 2;
        start_frame(32'h3000, 1'b0, '0);
        wait_beats(5, 200);
        rst = 1'b1;
        #1;
        chk_rst_outs("rst_mid");
        rq.delete();
        bus.i_Mem_Ack = 1'b0; bus.i_Mem_Rvalid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        beats = 0;
        repeat (30) tick();
        chk("rst_no_beats", beats, 0);
        chk("rst_idle", busy, 0);
        start_frame('0, 1'b0, '0);
        wait_idle(2000);
        chk("rst_frame_beats", beats, TOT);
        chk("rst_frame_err", ferr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end
endmodule
